// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: recovers SYNC/LEN/payload/CHK frames from a uart_rx byte stream.
// A valid frame is presented with a valid/ready handshake. While a frame is
// presented, the decoder holds off uart_rx. Rejected frames are counted and
// classified. An inter-byte watchdog abandons frames that stall part-way through.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         MAX_PAYLOAD    = 4,
  parameter int         TIMEOUT_CYCLES = 50_000_000/9600*20,
  parameter int         LW             = $clog2(MAX_PAYLOAD+1)
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [8*MAX_PAYLOAD-1:0] frame_data,
  output logic [LW-1:0]            frame_len,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [7:0]               err_count,
  output logic [1:0]               last_err
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES-1);
  localparam logic [1:0]    ERR_LEN  = 2'd1;
  localparam logic [1:0]    ERR_CHK  = 2'd2;
  localparam logic [1:0]    ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  state_t                   state_r;
  logic [8*MAX_PAYLOAD-1:0] frame_data_r;
  logic [LW-1:0]            frame_len_r;
  logic [LW-1:0]            idx_r;
  logic [7:0]               chk_r;
  logic [TW-1:0]            tmo_cnt_r;
  logic [7:0]               err_count_r;
  logic [1:0]               last_err_r;
  logic                     frame_valid_r;
  logic                     rx_ready_r;
  logic                     rx_acc_s;

  // Saturating increment so the error counter never wraps past 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

  assign rx_acc_s    = rx_valid & rx_ready_r;
  assign rx_ready    = rx_ready_r;
  assign frame_data  = frame_data_r;
  assign frame_len   = frame_len_r;
  assign frame_valid = frame_valid_r;
  assign err_count   = err_count_r;
  assign last_err    = last_err_r;

  // Frame FSM: parsing, payload capture, checksum, watchdog, error logging and output handshake.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= ST_HUNT;
      frame_data_r  <= {(8*MAX_PAYLOAD){1'b0}};
      frame_len_r   <= {LW{1'b0}};
      idx_r         <= {LW{1'b0}};
      chk_r         <= 8'h00;
      tmo_cnt_r     <= {TW{1'b0}};
      err_count_r   <= 8'h00;
      last_err_r    <= 2'd0;
      frame_valid_r <= 1'b0;
      rx_ready_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_HUNT: begin
          tmo_cnt_r <= {TW{1'b0}};
          if (rx_acc_s && (rx_byte == SYNC_BYTE)) begin
            state_r <= ST_LEN;
          end
        end

        ST_LEN, ST_PAYLOAD, ST_CHECK: begin
          if (rx_acc_s) begin
            // A byte arriving on the expiry cycle wins over the watchdog.
            tmo_cnt_r <= {TW{1'b0}};
            case (state_r)
              ST_LEN: begin
                if ((rx_byte != 8'd0) && (rx_byte <= 8'(MAX_PAYLOAD))) begin
                  frame_data_r <= {(8*MAX_PAYLOAD){1'b0}};
                  frame_len_r  <= rx_byte[LW-1:0];
                  idx_r        <= {LW{1'b0}};
                  chk_r        <= rx_byte;
                  state_r      <= ST_PAYLOAD;
                end else begin
                  // The bad length byte is consumed, not re-tried as a sync byte.
                  err_count_r <= sat_inc(err_count_r);
                  last_err_r  <= ERR_LEN;
                  state_r     <= ST_HUNT;
                end
              end
              ST_PAYLOAD: begin
                for (int i = 0; i < MAX_PAYLOAD; i++) begin
                  if (idx_r == LW'(i)) begin
                    frame_data_r[8*i +: 8] <= rx_byte;
                  end
                end
                chk_r <= chk_r ^ rx_byte;
                idx_r <= idx_r + LW'(1);
                if (idx_r == (frame_len_r - LW'(1))) begin
                  state_r <= ST_CHECK;
                end
              end
              ST_CHECK: begin
                if (rx_byte == chk_r) begin
                  frame_valid_r <= 1'b1;
                  rx_ready_r    <= 1'b0;
                  state_r       <= ST_OUT;
                end else begin
                  err_count_r <= sat_inc(err_count_r);
                  last_err_r  <= ERR_CHK;
                  state_r     <= ST_HUNT;
                end
              end
              default: begin
                state_r <= ST_HUNT;
              end
            endcase
          end else if (tmo_cnt_r >= TMO_LAST) begin
            tmo_cnt_r   <= {TW{1'b0}};
            err_count_r <= sat_inc(err_count_r);
            last_err_r  <= ERR_TMO;
            state_r     <= ST_HUNT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end

        ST_OUT: begin
          tmo_cnt_r <= {TW{1'b0}};
          if (frame_ready) begin
            frame_valid_r <= 1'b0;
            rx_ready_r    <= 1'b1;
            state_r       <= ST_HUNT;
          end
        end

        default: begin
          state_r       <= ST_HUNT;
          frame_valid_r <= 1'b0;
          rx_ready_r    <= 1'b1;
          tmo_cnt_r     <= {TW{1'b0}};
        end
      endcase
    end
  end

endmodule
